mem_arbiter: RTL and testbench

//  Two-requester controller for the core's single-port, 1-cycle-read word memory.

---
 rtl/mem_pkg.sv | 18 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, port indices
// and memory read/write strobe values.
package mem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational pick: single requester wins outright, a tie goes to
// LS under fixed priority, otherwise to the port that was not granted last.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_e      last_gnt_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (fixed_prio_i || last_gnt_i == PORT_IF) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port, 1-cycle-read memory between instruction fetch and
// load/store: arbitrates in IDLE, returns read data in RD_WAIT.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_rw,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy
);

  state_e              state_q, state_d;
  port_e               owner_q, owner_d;
  port_e               last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                mem_rw;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                rd_wait;

  // Requests arriving during RD_WAIT are masked and re-arbitrated in IDLE.
  assign rd_wait = (state_q == RD_WAIT);
  assign req     = rd_wait ? 2'b00 : {i_ls_req, i_if_req};

  rr_arb2 u_arb (
    .req_i        (req),
    .last_gnt_i   (last_gnt_q),
    .fixed_prio_i (FIXED_PRIO != 0),
    .gnt_o        (gnt)
  );

  // NOTE: every variable gets a default before the branches so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    mem_rw     = RW_READ;
    if (rd_wait) begin
      state_d = IDLE;
      if (owner_q == PORT_IF) if_rdata_d = i_mem_data;
      else                    ls_rdata_d = i_mem_data;
    end else if (gnt[PORT_IF]) begin
      last_gnt_d = PORT_IF;
      owner_d    = PORT_IF;
      state_d    = RD_WAIT;
      addr_d     = i_if_addr;
    end else if (gnt[PORT_LS]) begin
      last_gnt_d = PORT_LS;
      addr_d     = i_ls_addr;
      data_d     = i_ls_wdata;
      if (i_ls_we) begin
        mem_rw = RW_WRITE;
      end else begin
        owner_d = PORT_LS;
        state_d = RD_WAIT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= PORT_IF;
      last_gnt_q <= PORT_LS;
      addr_q     <= '0;
      data_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Read data is a passthrough for the owner in RD_WAIT and held otherwise.
  assign o_if_gnt    = gnt[PORT_IF];
  assign o_ls_gnt    = gnt[PORT_LS];
  assign o_if_rvalid = rd_wait && (owner_q == PORT_IF);
  assign o_ls_rvalid = rd_wait && (owner_q == PORT_LS);
  assign o_if_rdata  = if_rdata_d;
  assign o_ls_rdata  = ls_rdata_d;
  assign o_mem_addr  = addr_d;
  assign o_mem_data  = data_d;
  assign o_mem_rw    = mem_rw;
  assign o_busy      = rd_wait;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter: a round-robin and a
// fixed-priority instance, each checked every cycle against a transaction model.
module tb_mem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          ifr [2];
  logic [AW-1:0] ifa [2];
  logic          lsr [2];
  logic          lswe [2];
  logic [AW-1:0] lsa [2];
  logic [DW-1:0] lswd [2];
  logic          if_gnt [2];
  logic          if_rvalid [2];
  logic [DW-1:0] if_rdata [2];
  logic          ls_gnt [2];
  logic          ls_rvalid [2];
  logic [DW-1:0] ls_rdata [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] mem_data [2];
  logic          mem_rw [2];
  logic [DW-1:0] mem_q [2];
  logic          busy [2];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .resetn(resetn),
    .i_if_req(ifr[0]), .i_if_addr(ifa[0]), .o_if_gnt(if_gnt[0]),
    .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
    .i_ls_req(lsr[0]), .i_ls_we(lswe[0]), .i_ls_addr(lsa[0]), .i_ls_wdata(lswd[0]),
    .o_ls_gnt(ls_gnt[0]), .o_ls_rvalid(ls_rvalid[0]), .o_ls_rdata(ls_rdata[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_data(mem_data[0]), .o_mem_rw(mem_rw[0]),
    .i_mem_data(mem_q[0]), .o_busy(busy[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .i_if_req(ifr[1]), .i_if_addr(ifa[1]), .o_if_gnt(if_gnt[1]),
    .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
    .i_ls_req(lsr[1]), .i_ls_we(lswe[1]), .i_ls_addr(lsa[1]), .i_ls_wdata(lswd[1]),
    .o_ls_gnt(ls_gnt[1]), .o_ls_rvalid(ls_rvalid[1]), .o_ls_rdata(ls_rdata[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_data(mem_data[1]), .o_mem_rw(mem_rw[1]),
    .i_mem_data(mem_q[1]), .o_busy(busy[1])
  );

  // Memory instances: word array with a registered read port.
  logic [DW-1:0] mem     [2][32];
  logic [DW-1:0] ref_mem [2][32];
  logic          preload = 1'b1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preload) begin
        for (int i = 0; i < 32; i++) mem[d][i] <= ref_mem[d][i];
      end else if (mem_rw[d]) begin
        mem[d][mem_addr[d][AW-1:2]] <= mem_data[d];
      end
      mem_q[d] <= mem[d][mem_addr[d][AW-1:2]];
    end
  end

  // Transaction model state.
  bit            m_pend [2];
  int            m_owner [2];
  int            m_last [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] m_if_rd [2];
  logic [DW-1:0] m_ls_rd [2];
  logic [AW-1:0] m_addr [2];
  bit            m_ig [2];
  bit            m_lg [2];
  req_t          ifq [2][$];
  req_t          lsq [2][$];
  int            gnt_log [2][$];
  bit            rand_drop = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd);
    req_t r;
    r.v = v; r.we = we; r.addr = a; r.wd = wd;
    return r;
  endfunction

  function automatic int log_at(input int d, input int i);
    if (i < gnt_log[d].size()) return gnt_log[d][i];
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pend[d] = 0; m_owner[d] = 0; m_last[d] = 1;
      m_data[d] = '0; m_if_rd[d] = '0; m_ls_rd[d] = '0; m_addr[d] = '0;
      m_ig[d] = 0; m_lg[d] = 0;
      ifr[d] = 0; ifa[d] = '0; lsr[d] = 0; lswe[d] = 0; lsa[d] = '0; lswd[d] = '0;
      ifq[d].delete(); lsq[d].delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s d%0d if_gnt", tag, d), if_gnt[d], 0);
      check($sformatf("%s d%0d ls_gnt", tag, d), ls_gnt[d], 0);
      check($sformatf("%s d%0d if_rvalid", tag, d), if_rvalid[d], 0);
      check($sformatf("%s d%0d ls_rvalid", tag, d), ls_rvalid[d], 0);
      check($sformatf("%s d%0d if_rdata", tag, d), if_rdata[d], 0);
      check($sformatf("%s d%0d ls_rdata", tag, d), ls_rdata[d], 0);
      check($sformatf("%s d%0d mem_rw", tag, d), mem_rw[d], 0);
      check($sformatf("%s d%0d mem_addr", tag, d), mem_addr[d], 0);
      check($sformatf("%s d%0d mem_data", tag, d), mem_data[d], 0);
      check($sformatf("%s d%0d busy", tag, d), busy[d], 0);
    end
  endtask

  // One cycle of the reference: a read occupies the memory for two cycles,
  // a write for one; ties go by the instance's priority rule.
  task automatic eval(input int d);
    bit ei, el, eiv, elv, erw, ebusy;
    int win;
    ei = 0; el = 0; eiv = 0; elv = 0; erw = 0; win = -1;
    ebusy = m_pend[d];
    if (m_pend[d]) begin
      m_pend[d] = 0;
      if (m_owner[d] == 0) begin eiv = 1; m_if_rd[d] = m_data[d]; end
      else                 begin elv = 1; m_ls_rd[d] = m_data[d]; end
    end else if (ifr[d] && lsr[d]) win = (d == 1 || m_last[d] == 0) ? 1 : 0;
    else if (ifr[d]) win = 0;
    else if (lsr[d]) win = 1;
    if (win == 0) begin
      ei = 1; m_last[d] = 0; m_addr[d] = ifa[d];
      m_pend[d] = 1; m_owner[d] = 0; m_data[d] = ref_mem[d][ifa[d][AW-1:2]];
    end else if (win == 1) begin
      el = 1; m_last[d] = 1; m_addr[d] = lsa[d];
      if (lswe[d]) erw = 1;
      else begin
        m_pend[d] = 1; m_owner[d] = 1; m_data[d] = ref_mem[d][lsa[d][AW-1:2]];
      end
    end
    if (if_gnt[d]) gnt_log[d].push_back(0);
    if (ls_gnt[d]) gnt_log[d].push_back(1);
    check($sformatf("d%0d if_gnt", d), if_gnt[d], ei);
    check($sformatf("d%0d ls_gnt", d), ls_gnt[d], el);
    check($sformatf("d%0d if_rvalid", d), if_rvalid[d], eiv);
    check($sformatf("d%0d ls_rvalid", d), ls_rvalid[d], elv);
    check($sformatf("d%0d if_rdata", d), if_rdata[d], m_if_rd[d]);
    check($sformatf("d%0d ls_rdata", d), ls_rdata[d], m_ls_rd[d]);
    check($sformatf("d%0d mem_rw", d), mem_rw[d], erw);
    check($sformatf("d%0d mem_addr", d), mem_addr[d], m_addr[d]);
    check($sformatf("d%0d busy", d), busy[d], ebusy);
    if (erw) begin
      check($sformatf("d%0d mem_data", d), mem_data[d], lswd[d]);
      ref_mem[d][lsa[d][AW-1:2]] = lswd[d];
    end
    m_ig[d] = ei;
    m_lg[d] = el;
  endtask

  // Requests are held until granted (or occasionally abandoned), then the
  // next queued request is presented.
  task automatic drive();
    req_t e;
    for (int d = 0; d < 2; d++) begin
      if (!ifr[d] || m_ig[d] || (rand_drop && $urandom_range(7) == 0)) begin
        ifr[d] = 0;
        if (ifq[d].size() > 0) begin
          e = ifq[d].pop_front(); ifr[d] = e.v; ifa[d] = e.addr;
        end
      end
      if (!lsr[d] || m_lg[d] || (rand_drop && $urandom_range(7) == 0)) begin
        lsr[d] = 0;
        if (lsq[d].size() > 0) begin
          e = lsq[d].pop_front(); lsr[d] = e.v; lswe[d] = e.we; lsa[d] = e.addr; lswd[d] = e.wd;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (resetn) for (int d = 0; d < 2; d++) eval(d);
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit activity();
    bit a;
    a = 0;
    for (int d = 0; d < 2; d++)
      if (ifr[d] || lsr[d] || m_pend[d] || ifq[d].size() > 0 || lsq[d].size() > 0) a = 1;
    return a;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (activity() && n < budget) begin
      step();
      n++;
    end
    check({tag, " drain_timeout"}, (n >= budget), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) ref_mem[d][i] = $urandom;
    ref_mem[0][2] = 32'h0000_0013;
    ref_mem[1][2] = 32'h0000_0013;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    preload = 1'b0;
    resetn  = 1'b1;

    // IF-only read of MEM[2].
    ifq[0].push_back(mk(1, 0, 7'h08, '0));
    drain("t1", 20);
    check("t1 if_rdata", if_rdata[0], 32'h0000_0013);

    // LS write then read back the same word.
    lsq[0].push_back(mk(1, 1, 7'h04, 32'hDEAD_BEEF));
    lsq[0].push_back(mk(1, 0, 7'h04, '0));
    drain("t2", 20);
    check("t2 ls_rdata", ls_rdata[0], 32'hDEAD_BEEF);

    // Both ports hold read requests on both instances.
    gnt_log[0].delete();
    gnt_log[1].delete();
    for (int d = 0; d < 2; d++) begin
      ifq[d].push_back(mk(1, 0, 7'h0C, '0));
      ifq[d].push_back(mk(1, 0, 7'h10, '0));
      lsq[d].push_back(mk(1, 0, 7'h14, '0));
      lsq[d].push_back(mk(1, 0, 7'h18, '0));
      lsq[d].push_back(mk(1, 0, 7'h1C, '0));
    end
    drain("t3", 40);
    check("t3 rr grant0", log_at(0, 0), 0);
    check("t3 rr grant1", log_at(0, 1), 1);
    check("t3 rr grant2", log_at(0, 2), 0);
    check("t4 fp grant0", log_at(1, 0), 1);
    check("t4 fp grant1", log_at(1, 1), 1);
    check("t4 fp grant2", log_at(1, 2), 1);
    check("t4 fp grant3", log_at(1, 3), 0);

    // Back-to-back LS writes contending with IF, then read back.
    for (int d = 0; d < 2; d++) begin
      ifq[d].push_back(mk(1, 0, 7'h20, '0));
      lsq[d].push_back(mk(1, 1, 7'h00, 32'h1111_1111));
      lsq[d].push_back(mk(1, 1, 7'h04, 32'h2222_2222));
      lsq[d].push_back(mk(1, 1, 7'h08, 32'h3333_3333));
    end
    drain("t5w", 40);
    for (int d = 0; d < 2; d++) begin
      lsq[d].push_back(mk(1, 0, 7'h00, '0));
      lsq[d].push_back(mk(1, 0, 7'h05, '0));
      lsq[d].push_back(mk(1, 0, 7'h0B, '0));
    end
    drain("t5r", 40);
    check("t5 rr ls_rdata", ls_rdata[0], 32'h3333_3333);
    check("t5 fp ls_rdata", ls_rdata[1], 32'h3333_3333);

    // Randomized traffic with occasional abandoned requests.
    rand_drop = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (ifq[d].size() < 2)
          ifq[d].push_back(mk($urandom_range(3) != 0, 0, AW'($urandom_range(127)), '0));
        if (lsq[d].size() < 2)
          lsq[d].push_back(mk($urandom_range(3) != 0, $urandom_range(1) == 1,
                              AW'($urandom_range(127)), $urandom));
      end
      step();
    end
    rand_drop = 1'b0;
    drain("rand", 60);

    // Reset asserted in the RD_WAIT cycle.
    ifq[0].push_back(mk(1, 0, 7'h08, '0));
    n = 0;
    while (!m_pend[0] && n < 10) begin
      step();
      n++;
    end
    check("t6 reached RD_WAIT", m_pend[0], 1);
    check("t6 rvalid before reset", if_rvalid[0], 1);
    resetn = 1'b0;
    #1;
    check("t6 rvalid dropped", if_rvalid[0], 0);
    check("t6 busy dropped", busy[0], 0);
    model_reset();
    #2;
    check_reset_outputs("t6");
    resetn = 1'b1;
    repeat (5) step();
    ifq[0].push_back(mk(1, 0, 7'h0C, '0));
    drain("t6 post", 20);
    check("t6 post rdata", if_rdata[0], ref_mem[0][3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
